// File: rtl/exp_sub_arbiter_if.sv
// Request/response bundle for exp_sub_arbiter: two requesters sharing one
// exponent subtractor over valid/ready handshakes.
interface exp_sub_arbiter_if #(
    parameter int SIZE_EXP = 8
);
    logic [1:0]            i_req_valid;
    logic [1:0]            o_req_ready;
    logic [2*SIZE_EXP-1:0] i_req_a;
    logic [2*SIZE_EXP-1:0] i_req_b;
    logic [1:0]            o_rsp_valid;
    logic [1:0]            i_rsp_ready;
    logic [SIZE_EXP-1:0]   o_rsp_diff;
    logic                  o_rsp_swap;
    logic                  o_busy;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_diff, o_rsp_swap, o_busy
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_diff, o_rsp_swap, o_busy
    );
endinterface

// File: rtl/exp_sub_arbiter.sv
// Round-robin arbiter sharing one EXP_sub between two requesters; returns
// |A-B| and swap (B > A) using one pass, or two passes when A < B.
module EXP_sub #(
    parameter int SIZE_EXP_SUB = 8
) (
    input  logic [SIZE_EXP_SUB-1:0] i_a,
    input  logic [SIZE_EXP_SUB-1:0] i_b,
    output logic [SIZE_EXP_SUB-1:0] o_diff
);
    assign o_diff = i_a - i_b;
endmodule

module exp_sub_arbiter #(
    parameter int SIZE_EXP = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    exp_sub_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_SUB1, S_SUB2, S_RESP} state_t;

    state_t              r_state, w_next;
    logic [SIZE_EXP-1:0] r_a, r_b, r_diff;
    logic                r_gnt, r_ptr, r_swap;
    logic [SIZE_EXP-1:0] w_sub_x, w_sub_y, w_sub_diff, w_a_sel, w_b_sel;
    logic                w_win, w_accept, w_done, w_borrow;
    logic [1:0]          w_req_ready, w_rsp_valid;

    // Pointer only decides ties; a lone requester wins outright.
    assign w_win    = (&bus.i_req_valid) ? r_ptr : bus.i_req_valid[1];
    assign w_a_sel  = w_win ? bus.i_req_a[SIZE_EXP +: SIZE_EXP] : bus.i_req_a[0 +: SIZE_EXP];
    assign w_b_sel  = w_win ? bus.i_req_b[SIZE_EXP +: SIZE_EXP] : bus.i_req_b[0 +: SIZE_EXP];
    assign w_borrow = (r_a < r_b);

    // Second pass reverses the operands so the result is always |A-B|.
    assign w_sub_x = (r_state == S_SUB2) ? r_b : r_a;
    assign w_sub_y = (r_state == S_SUB2) ? r_a : r_b;

    EXP_sub #(.SIZE_EXP_SUB(SIZE_EXP)) u_exp_sub (
        .i_a    (w_sub_x),
        .i_b    (w_sub_y),
        .o_diff (w_sub_diff)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 2'b00;
        w_rsp_valid = 2'b00;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_rst && (|bus.i_req_valid)) begin
                    w_req_ready[w_win] = 1'b1;
                    w_accept           = 1'b1;
                    w_next             = S_SUB1;
                end
            end
            S_SUB1: w_next = w_borrow ? S_SUB2 : S_RESP;
            S_SUB2: w_next = S_RESP;
            S_RESP: begin
                w_rsp_valid[r_gnt] = 1'b1;
                if (bus.i_rsp_ready[r_gnt]) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_gnt  <= 1'b0;
            r_ptr  <= 1'b0;
            r_swap <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= w_a_sel;
                r_b   <= w_b_sel;
                r_gnt <= w_win;
            end
            if (r_state == S_SUB1) begin
                r_diff <= w_sub_diff;
                r_swap <= w_borrow;
            end
            if (r_state == S_SUB2) r_diff <= w_sub_diff;
            if (w_done)            r_ptr  <= ~r_gnt;
        end
    end

    assign bus.o_req_ready = w_req_ready;
    assign bus.o_rsp_valid = w_rsp_valid;
    assign bus.o_rsp_diff  = r_diff;
    assign bus.o_rsp_swap  = r_swap;
    assign bus.o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_exp_sub_arbiter.sv
// Bench for exp_sub_arbiter: transaction-level model checked every cycle,
// directed literal cases, then randomized traffic with random resets.
module tb_exp_sub_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exp_sub_arbiter_if #(.SIZE_EXP(W)) bus ();

    exp_sub_arbiter #(.SIZE_EXP(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a pending request waits a number of edges
    // (1 if A>=B, 2 if A<B) before its response shows, then waits for ready.
    bit       m_pend = 1'b0;
    int       m_wait = 0;
    bit       m_id   = 1'b0;
    bit       m_ptr  = 1'b0;
    int       m_diff = 0;
    bit       m_swap = 1'b0;

    function automatic bit pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p;
        if (v == 2'b10) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int a, b;
        if (rst) begin
            m_pend = 1'b0;
            m_ptr  = 1'b0;
        end else if (!m_pend) begin
            if (bus.i_req_valid != 2'b00) begin
                m_id   = pick(bus.i_req_valid, m_ptr);
                a      = int'(bus.i_req_a[m_id*W +: W]);
                b      = int'(bus.i_req_b[m_id*W +: W]);
                m_diff = (a >= b) ? a - b : b - a;
                m_swap = (b > a);
                m_wait = (a < b) ? 2 : 1;
                m_pend = 1'b1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (bus.i_rsp_ready[m_id]) begin
            m_pend = 1'b0;
            m_ptr  = ~m_id;
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_rr, exp_rv;
        if (chk_en) begin
            exp_rr = 2'b00;
            exp_rv = 2'b00;
            if (!m_pend) begin
                if (!rst && bus.i_req_valid != 2'b00) exp_rr[pick(bus.i_req_valid, m_ptr)] = 1'b1;
            end else if (m_wait == 0) begin
                exp_rv[m_id] = 1'b1;
            end
            chk("m_req_ready", int'(bus.o_req_ready), int'(exp_rr));
            chk("m_rsp_valid", int'(bus.o_rsp_valid), int'(exp_rv));
            chk("m_busy", int'(bus.o_busy), int'(m_pend));
            if (exp_rv != 2'b00) begin
                chk("m_diff", int'(bus.o_rsp_diff), m_diff);
                chk("m_swap", int'(bus.o_rsp_swap), int'(m_swap));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait up to a bound for a response; returns cycles since the accept cycle.
    task automatic wait_rsp(output int lat, output bit found);
        found = 1'b0;
        lat   = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            lat++;
            if (bus.o_rsp_valid != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("rsp_timeout", 0, 1);
    endtask

    // Called just after an edge with the DUT idle.
    task automatic txn(input int id, input int a, input int b, input bit chg,
                       input int e_diff, input int e_swap, input int e_lat);
        int lat;
        bit found;
        bus.i_req_valid[id]       = 1'b1;
        bus.i_req_a[id*W +: W]    = a[W-1:0];
        bus.i_req_b[id*W +: W]    = b[W-1:0];
        @(negedge clk);
        chk("acc_ready", int'(bus.o_req_ready), 1 << id);
        step();
        bus.i_req_valid = 2'b00;
        if (chg) begin
            bus.i_req_a[id*W +: W] = 8'd1;
            bus.i_req_b[id*W +: W] = ~b[W-1:0];
        end
        wait_rsp(lat, found);
        if (found) begin
            chk("lit_valid", int'(bus.o_rsp_valid), 1 << id);
            chk("lit_diff", int'(bus.o_rsp_diff), e_diff);
            chk("lit_swap", int'(bus.o_rsp_swap), e_swap);
            chk("lit_latency", lat, e_lat);
        end
        step();
    endtask

    initial begin
        int lat, nrsp, cyc;
        bit found;
        int ids[3];
        int swaps[3];
        bus.i_req_valid = 2'b01;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_rsp_ready = 2'b11;

        // Reset: ready must stay low even with a valid request present.
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", int'(bus.o_req_ready), 0);
        chk("rst_rsp_valid", int'(bus.o_rsp_valid), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_diff", int'(bus.o_rsp_diff), 0);
        chk("rst_swap", int'(bus.o_rsp_swap), 0);
        step();
        bus.i_req_valid = 2'b00;
        rst = 1'b0;
        step();

        txn(0, 130, 127, 1'b0, 3, 0, 2);
        txn(1, 100, 140, 1'b0, 40, 1, 3);
        txn(1, 0, 255, 1'b0, 255, 1, 3);
        txn(0, 127, 127, 1'b0, 0, 0, 2);
        txn(0, 255, 0, 1'b0, 255, 0, 2);
        txn(0, 200, 50, 1'b1, 150, 0, 2);

        // Round robin with both valid continuously from reset.
        rst = 1'b1;
        bus.i_req_valid = 2'b11;
        bus.i_req_a = {8'd5, 8'd10};
        bus.i_req_b = {8'd10, 8'd5};
        step();
        rst = 1'b0;
        nrsp = 0;
        for (cyc = 0; cyc < 40 && nrsp < 3; cyc++) begin
            @(negedge clk);
            if (bus.o_req_ready == 2'b11) chk("rr_onehot", 3, 0);
            if (bus.o_rsp_valid != 2'b00) begin
                ids[nrsp]   = (bus.o_rsp_valid == 2'b10) ? 1 : 0;
                swaps[nrsp] = int'(bus.o_rsp_swap);
                chk("rr_diff", int'(bus.o_rsp_diff), 5);
                nrsp++;
            end
            if (nrsp == 3) bus.i_req_valid = 2'b00;
            step();
            bus.i_req_valid = (nrsp == 3) ? 2'b00 : bus.i_req_valid;
        end
        chk("rr_count", nrsp, 3);
        if (nrsp == 3) begin
            chk("rr_id0", ids[0], 0);
            chk("rr_id1", ids[1], 1);
            chk("rr_id2", ids[2], 0);
            chk("rr_swap0", swaps[0], 0);
            chk("rr_swap1", swaps[1], 1);
        end
        bus.i_req_valid = 2'b00;
        step();

        // Backpressure: only the granted requester's ready matters.
        bus.i_rsp_ready = 2'b10;
        bus.i_req_valid = 2'b01;
        bus.i_req_a[7:0] = 8'd50;
        bus.i_req_b[7:0] = 8'd20;
        step();
        bus.i_req_valid = 2'b00;
        wait_rsp(lat, found);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(bus.o_rsp_valid), 1);
            chk("bp_diff", int'(bus.o_rsp_diff), 30);
            chk("bp_swap", int'(bus.o_rsp_swap), 0);
            step();
            if (k == 4) bus.i_rsp_ready = 2'b01;
            @(negedge clk);
        end
        chk("bp_last_valid", int'(bus.o_rsp_valid), 1);
        step();
        @(negedge clk);
        chk("bp_done_busy", int'(bus.o_busy), 0);
        bus.i_rsp_ready = 2'b11;
        step();

        // Reset while in the second subtract pass.
        bus.i_req_valid = 2'b01;
        bus.i_req_a[7:0] = 8'd5;
        bus.i_req_b[7:0] = 8'd9;
        step();
        bus.i_req_valid = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_req_valid = 2'b10;
        bus.i_req_a[15:8] = 8'd77;
        bus.i_req_b[15:8] = 8'd7;
        @(negedge clk);
        chk("mr_rsp_valid", int'(bus.o_rsp_valid), 0);
        chk("mr_busy", int'(bus.o_busy), 0);
        chk("mr_diff", int'(bus.o_rsp_diff), 0);
        chk("mr_swap", int'(bus.o_rsp_swap), 0);
        chk("mr_req_ready", int'(bus.o_req_ready), 2);
        step();
        bus.i_req_valid = 2'b00;
        wait_rsp(lat, found);
        if (found) chk("mr_after_diff", int'(bus.o_rsp_diff), 70);
        step();

        // Random traffic; the model process does the checking.
        for (int c = 0; c < 3000; c++) begin
            int mode;
            bus.i_req_valid = 2'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 9));
            bus.i_req_a = 16'($urandom);
            bus.i_req_b = 16'($urandom);
            if (mode == 0) bus.i_req_b = bus.i_req_a;
            if (mode == 1) bus.i_req_a = 16'h0000;
            if (mode == 2) bus.i_req_b = 16'hFFFF;
            bus.i_rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        bus.i_req_valid = 2'b00;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
